// File: rtl/vedic_pp_combine.sv
// vedic_pp_combine: two-stage valid/ready recombination of four Vedic sub-products into a 4H-bit product
// Ports: clk/rst_n (async active-low); in_valid/in_ready with pp_ll, pp_lh, pp_hl, pp_hh, in_tag;
//        out_valid/out_ready with out_product, out_tag.
module vedic_pp_combine #(
  parameter int HALF_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   pp_ll,
  input  logic [2*HALF_W-1:0]   pp_lh,
  input  logic [2*HALF_W-1:0]   pp_hl,
  input  logic [2*HALF_W-1:0]   pp_hh,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   out_product,
  output logic [TAG_W-1:0]      out_tag
);
  localparam int P = 2*HALF_W;
  localparam int W = 4*HALF_W;
  logic             s1_valid;
  logic [P:0]       s1_mid;
  logic [P-1:0]     s1_ll, s1_hh;
  logic [TAG_W-1:0] s1_tag;
  logic             in_fire, s2_load;
  logic [W-1:0]     s2_sum;
  assign in_ready = ~s1_valid | ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  // Shift happens at full product width so any carry past bit W-1 falls off.
  assign s2_sum   = {s1_hh, s1_ll} + (W'(s1_mid) << HALF_W);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_mid      <= '0;
      s1_ll       <= '0;
      s1_hh       <= '0;
      s1_tag      <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else begin
      if (in_fire) begin
        s1_mid <= {1'b0, pp_lh} + {1'b0, pp_hl};
        s1_ll  <= pp_ll;
        s1_hh  <= pp_hh;
        s1_tag <= in_tag;
      end
      s1_valid <= in_fire | (s1_valid & ~s2_load);
      if (s2_load) begin
        out_product <= s2_sum;
        out_tag     <= s1_tag;
      end
      out_valid <= s2_load | (out_valid & ~out_ready);
    end
  end
endmodule

// File: tb/tb_vedic_pp_combine.sv
// tb_vedic_pp_combine: directed self-checking bench for vedic_pp_combine
module tb_vedic_pp_combine;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_product;
  int total = 0;
  int bad = 0;
  vedic_pp_combine #(.HALF_W(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pp_ll(pp_ll), .pp_lh(pp_lh), .pp_hl(pp_hl), .pp_hh(pp_hh), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .out_tag(out_tag)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_pp(input logic [15:0] ll, lh, hl, hh, input logic [3:0] tg);
    pp_ll = ll; pp_lh = lh; pp_hl = hl; pp_hh = hh; in_tag = tg;
  endtask
  task automatic set_ab(input logic [15:0] a, b, input logic [3:0] tg);
    logic [15:0] ll, lh, hl, hh;
    ll = a[7:0] * b[7:0];
    lh = a[7:0] * b[15:8];
    hl = a[15:8] * b[7:0];
    hh = a[15:8] * b[15:8];
    set_pp(ll, lh, hl, hh, tg);
  endtask
  task automatic run_one(input string nm, input logic [15:0] ll, lh, hl, hh,
                         input logic [3:0] tg, input logic [31:0] exp);
    set_pp(ll, lh, hl, hh, tg);
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk({nm, "_lat1_valid"}, 32'(out_valid), 32'd0);
    tick;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_product"}, out_product, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tg));
    tick;
    chk({nm, "_drained"}, 32'(out_valid), 32'd0);
  endtask
  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic [15:0] ba [2];
  logic [15:0] bb [2];
  logic [31:0] held_p;
  logic [3:0]  held_t;
  int acc;
  int idx;
  logic rdy;
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_pp(16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_product", out_product, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    run_one("single", 16'h1860, 16'h1178, 16'h0870, 16'h060C, 4'd3, 32'h06260060);
    run_one("max", 16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 4'd5, 32'hFFFE0001);
    run_one("wrap", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd6, 32'h01FFFDFF);
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'hA5C3 + 16'(i) * 16'h1357;
      sb[i] = 16'hFFFF - 16'(i) * 16'h0F0F;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ab(sa[i], sb[i], 4'(i));
      in_valid = 1'b1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick;
      if (i == 0) chk("stream_first_lat", 32'(out_valid), 32'd0);
      else begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_tag", 32'(out_tag), 32'(i - 1));
        chk("stream_product", out_product, 32'(sa[i-1]) * 32'(sb[i-1]));
      end
    end
    in_valid = 1'b0;
    tick;
    chk("stream_last_valid", 32'(out_valid), 32'd1);
    chk("stream_last_tag", 32'(out_tag), 32'd7);
    chk("stream_last_product", out_product, 32'(sa[7]) * 32'(sb[7]));
    tick;
    chk("stream_drained", 32'(out_valid), 32'd0);
    ba[0] = 16'h1234; bb[0] = 16'h5678;
    ba[1] = 16'hBEEF; bb[1] = 16'hCAFE;
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    set_ab(ba[0], bb[0], 4'd9);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rdy = in_ready;
      tick;
      if (rdy) begin
        acc++;
        idx++;
        if (idx < 2) set_ab(ba[idx], bb[idx], 4'(9 + idx));
        else set_ab(16'hFFFF, 16'hFFFF, 4'd15);
      end
      if (c == 2) begin
        held_p = out_product;
        held_t = out_tag;
      end
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_product_stable", out_product, held_p);
    chk("bp_tag_stable", 32'(out_tag), 32'(held_t));
    chk("bp_product", out_product, 32'h06260060);
    chk("bp_tag", 32'(out_tag), 32'd9);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_drain2_valid", 32'(out_valid), 32'd1);
    chk("bp_drain2_tag", 32'(out_tag), 32'd10);
    chk("bp_drain2_product", out_product, 32'hBEEF * 32'hCAFE);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick;
    chk("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    set_ab(16'h0F0F, 16'hF0F0, 4'd12);
    in_valid = 1'b1;
    tick;
    set_ab(16'h8001, 16'h7FFF, 4'd13);
    tick;
    in_valid = 1'b0;
    chk("rstmid_loaded", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_product", out_product, 32'd0);
    chk("rstmid_tag", 32'(out_tag), 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("rstmid_no_stale", 32'(out_valid), 32'd0);
    tick;
    chk("rstmid_no_stale2", 32'(out_valid), 32'd0);
    run_one("after_rst", 16'h1860, 16'h1178, 16'h0870, 16'h060C, 4'd4, 32'h06260060);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
